// File: rtl/mdu_iterative.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iterative
// Brief    : Multi-cycle M-extension unit: shift-add multiply, restoring divide.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_iterative #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              kill,
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   result,
    output logic [2*XLEN-1:0] result_full
);

    localparam int                 c_CNT_W     = $clog2(XLEN) + 1;
    localparam logic [c_CNT_W-1:0] c_MUL_ITERS = c_CNT_W'(XLEN / MUL_BITS);
    localparam logic [c_CNT_W-1:0] c_DIV_ITERS = c_CNT_W'(XLEN);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [XLEN-1:0]    c_MIN       = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_op;
    logic                r_sign_diff;
    logic                r_sign_a;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_quo;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_div;
    logic [XLEN-1:0]     r_result;
    logic [2*XLEN-1:0]   r_result_full;

    // ---------------------------------------------------------------- accept
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div_by_zero;
    logic                w_overflow;
    logic                w_special;
    logic [2*XLEN-1:0]   w_special_full;
    logic                w_accept;
    logic                w_last;

    assign w_a_signed     = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign w_b_signed     = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign w_sign_a       = a[XLEN-1] & w_a_signed;
    assign w_sign_b       = b[XLEN-1] & w_b_signed;
    assign w_mag_a        = w_sign_a ? -a : a;
    assign w_mag_b        = w_sign_b ? -b : b;
    assign w_div_by_zero  = op[2] && (b == '0);
    assign w_overflow     = op[2] && !op[0] && (a == c_MIN) && (b == '1);
    assign w_special      = w_div_by_zero || w_overflow;
    // Full-width special results are laid out as {remainder, quotient}
    assign w_special_full = w_div_by_zero ? {a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, c_MIN};
    assign w_accept       = (r_state == S_IDLE) && start && !kill;
    assign w_last         = (r_cnt == c_CNT_ONE);

    // ------------------------------------------------------------ iteration
    logic [2*XLEN-1:0]   w_partial;
    logic [2*XLEN-1:0]   w_acc_next;
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN:0]       w_rem_diff;
    logic                w_qbit;
    logic [XLEN-1:0]     w_rem_next;
    logic [XLEN-1:0]     w_quo_next;

    assign w_partial  = r_mcand * (2*XLEN)'(r_mplier[MUL_BITS-1:0]);
    assign w_acc_next = r_acc + w_partial;

    // Working remainder is XLEN+1 bits; the restored value always fits XLEN
    assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_div};
    assign w_qbit     = ~w_rem_diff[XLEN];
    assign w_rem_next = w_qbit ? w_rem_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_next = {r_quo[XLEN-2:0], w_qbit};

    // ---------------------------------------------------------- commit path
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [2*XLEN-1:0]   w_final_full;
    logic [2:0]          w_final_op;
    logic                w_commit;
    logic                w_sel_high;
    logic [XLEN-1:0]     w_final_res;

    assign w_prod_fix = r_sign_diff ? -w_acc_next : w_acc_next;
    assign w_quo_fix  = r_sign_diff ? -w_quo_next : w_quo_next;
    assign w_rem_fix  = r_sign_a    ? -w_rem_next : w_rem_next;

    always_comb begin
        w_final_full = w_special_full;
        w_final_op   = op;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: w_commit = w_accept && w_special;
            S_MUL: begin
                w_final_full = w_prod_fix;
                w_final_op   = r_op;
                w_commit     = w_last;
            end
            S_DIV: begin
                w_final_full = {w_rem_fix, w_quo_fix};
                w_final_op   = r_op;
                w_commit     = w_last;
            end
            default: w_commit = 1'b0;
        endcase
        if (kill) begin
            w_commit = 1'b0;
        end
    end

    // High half: mulh/mulhsu/mulhu and rem/remu
    assign w_sel_high  = w_final_op[2] ? w_final_op[1] : (w_final_op[1:0] != 2'b00);
    assign w_final_res = w_sel_high ? w_final_full[2*XLEN-1:XLEN] : w_final_full[XLEN-1:0];

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_special) begin
                        w_state_next = S_DONE;
                    end else if (op[2]) begin
                        w_state_next = S_DIV;
                    end else begin
                        w_state_next = S_MUL;
                    end
                end
            end
            S_MUL:   if (w_last) w_state_next = S_DONE;
            S_DIV:   if (w_last) w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
        if (kill) begin
            w_state_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op          <= '0;
            r_sign_diff   <= 1'b0;
            r_sign_a      <= 1'b0;
            r_cnt         <= '0;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_acc         <= '0;
            r_quo         <= '0;
            r_rem         <= '0;
            r_div         <= '0;
            r_result      <= '0;
            r_result_full <= '0;
        end else begin
            if (w_accept) begin
                r_op        <= op;
                r_sign_diff <= w_sign_a ^ w_sign_b;
                r_sign_a    <= w_sign_a;
                r_cnt       <= op[2] ? c_DIV_ITERS : c_MUL_ITERS;
                r_mcand     <= {{XLEN{1'b0}}, w_mag_a};
                r_mplier    <= w_mag_b;
                r_acc       <= '0;
                r_quo       <= w_mag_a;
                r_rem       <= '0;
                r_div       <= w_mag_b;
            end
            if (r_state == S_MUL) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << MUL_BITS;
                r_mplier <= r_mplier >> MUL_BITS;
                r_cnt    <= r_cnt - c_CNT_ONE;
            end
            if (r_state == S_DIV) begin
                r_quo <= w_quo_next;
                r_rem <= w_rem_next;
                r_cnt <= r_cnt - c_CNT_ONE;
            end
            if (w_commit) begin
                r_result      <= w_final_res;
                r_result_full <= w_final_full;
            end
        end
    end

    assign ready       = (r_state == S_IDLE);
    assign busy        = (r_state == S_MUL) || (r_state == S_DIV);
    assign done        = (r_state == S_DONE);
    assign result      = r_result;
    assign result_full = r_result_full;

endmodule
`default_nettype wire
